// File: rtl/vtc_pkg.sv
// vtc_pkg: shared timing defaults, pattern mode encodings and colour constants
// for the 640x480 test-pattern source.
package vtc_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned WIN_H0_DEF   = 144;
  localparam int unsigned WIN_V0_DEF   = 104;
  localparam int unsigned WIN_SIZE_DEF = 32;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned HCNT_W = 12;
  localparam int unsigned VCNT_W = 11;
  localparam int unsigned RGB_W  = 24;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned N_BARS = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_TARGET = 2'd2,
    MODE_MOVE   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;
  localparam logic [RGB_W-1:0] COLOR_BG     = 24'h404040;
  localparam logic [RGB_W-1:0] COLOR_MARKER = 24'hFF0000;

  // Bar colour by bar index, left to right.
  function automatic rgb_t bar_color(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return rgb_t'(c);
  endfunction

endpackage

// File: rtl/video_timing.sv
// video_timing: free-running h/v raster counters plus registered hsync/vsync/de/
// frame_start decode; live counters are exported so the pattern stage stays aligned.
module video_timing
  import vtc_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic              PClk,
  input  logic              Rst_n,
  output logic [HCNT_W-1:0] h_cnt,
  output logic [VCNT_W-1:0] v_cnt,
  output logic              origin_c,
  output logic              active_c,
  output logic [HCNT_W-1:0] VtcHCnt,
  output logic [VCNT_W-1:0] VtcVCnt,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

  logic hsync_c;
  logic vsync_c;

  // Raster counters: h wraps every line, v advances on h wrap.
  always_ff @(posedge PClk or negedge Rst_n) begin
    if (!Rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HCNT_W'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VCNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + VCNT_W'(1);
    end else begin
      h_cnt <= h_cnt + HCNT_W'(1);
    end
  end

  always_comb begin
    origin_c = (h_cnt == '0) && (v_cnt == '0);
    active_c = (h_cnt < HCNT_W'(H_ACTIVE)) && (v_cnt < VCNT_W'(V_ACTIVE));
    hsync_c  = !((h_cnt >= HCNT_W'(HS_FIRST)) && (h_cnt <= HCNT_W'(HS_LAST)));
    vsync_c  = !((v_cnt >= VCNT_W'(VS_FIRST)) && (v_cnt <= VCNT_W'(VS_LAST)));
  end

  always_ff @(posedge PClk or negedge Rst_n) begin
    if (!Rst_n) begin
      VtcHCnt     <= '0;
      VtcVCnt     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VtcHCnt     <= h_cnt;
      VtcVCnt     <= v_cnt;
      hsync       <= hsync_c;
      vsync       <= vsync_c;
      de          <= active_c;
      frame_start <= origin_c;
    end
  end

endmodule

// File: rtl/vtc_pattern_gen.sv
// vtc_pattern_gen: 640x480@60 timing source with solid / bar / target test patterns.
// Optional crosshair overlay (marker_h/marker_v ports) when VTC_MARKER_EN is defined.
module vtc_pattern_gen
  import vtc_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned WIN_H0   = WIN_H0_DEF,
  parameter int unsigned WIN_V0   = WIN_V0_DEF,
  parameter int unsigned WIN_SIZE = WIN_SIZE_DEF
) (
  input  logic              PClk,
  input  logic              Rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic [RGB_W-1:0]  fill_color,
  output logic [HCNT_W-1:0] VtcHCnt,
  output logic [VCNT_W-1:0] VtcVCnt,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [RGB_W-1:0]  RGB24,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
`ifdef VTC_MARKER_EN
  ,
  input  logic [HCNT_W-1:0] marker_h,
  input  logic [VCNT_W-1:0] marker_v
`endif
);

  localparam int unsigned BAR_W   = H_ACTIVE / N_BARS;
  localparam int unsigned X0_LAST = H_ACTIVE - WIN_SIZE;

  logic [HCNT_W-1:0] h_cnt;
  logic [VCNT_W-1:0] v_cnt;
  logic              origin_c;
  logic              active_c;

  mode_e             sh_mode;
  rgb_t              sh_fill;
  logic [HCNT_W-1:0] x0;

  mode_e             mode_eff_c;
  rgb_t              fill_eff_c;
  logic [HCNT_W-1:0] x0_nxt_c;
  logic [HCNT_W-1:0] x0_eff_c;
  logic [FCNT_W-1:0] frame_cnt_nxt_c;
  logic [2:0]        bar_idx_c;
  logic [HCNT_W-1:0] win_x0_c;
  logic              in_win_c;
  rgb_t              pix_c;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .PClk        (PClk),
    .Rst_n       (Rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .origin_c    (origin_c),
    .active_c    (active_c),
    .VtcHCnt     (VtcHCnt),
    .VtcVCnt     (VtcVCnt),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .frame_start (frame_start)
  );

  // At pixel (0,0) the incoming settings already apply, so frames never tear.
  always_comb begin
    mode_eff_c       = sh_mode;
    fill_eff_c       = sh_fill;
    frame_cnt_nxt_c  = frame_cnt + FCNT_W'(1);
    if (origin_c) begin
      mode_eff_c = mode_e'(mode);
      fill_eff_c = rgb_t'(fill_color);
    end
  end

  // x0 tracks frame_cnt mod (H_ACTIVE-WIN_SIZE+1) incrementally; resyncs on counter wrap.
  always_comb begin
    if (frame_cnt_nxt_c == '0) begin
      x0_nxt_c = '0;
    end else if (x0 == HCNT_W'(X0_LAST)) begin
      x0_nxt_c = '0;
    end else begin
      x0_nxt_c = x0 + HCNT_W'(1);
    end
    x0_eff_c = origin_c ? x0_nxt_c : x0;
  end

  always_comb begin
    pix_c     = '0;
    bar_idx_c = '0;
    for (int unsigned i = 1; i < N_BARS; i++) begin
      if (h_cnt >= HCNT_W'(i * BAR_W)) bar_idx_c = 3'(i);
    end
    win_x0_c = (mode_eff_c == MODE_MOVE) ? x0_eff_c : HCNT_W'(WIN_H0);
    in_win_c = (h_cnt >= win_x0_c) && (h_cnt < win_x0_c + HCNT_W'(WIN_SIZE)) &&
               (v_cnt >= VCNT_W'(WIN_V0)) && (v_cnt < VCNT_W'(WIN_V0 + WIN_SIZE));
    case (mode_eff_c)
      MODE_SOLID: pix_c = fill_eff_c;
      MODE_BARS:  pix_c = bar_color(bar_idx_c);
      default:    pix_c = in_win_c ? fill_eff_c : rgb_t'(COLOR_BG);
    endcase
`ifdef VTC_MARKER_EN
    if ((h_cnt == marker_h) || (v_cnt == marker_v)) pix_c = rgb_t'(COLOR_MARKER);
`endif
    if (!active_c) pix_c = '0;
  end

  // Shadow capture and frame bookkeeping happen only at the raster origin.
  always_ff @(posedge PClk or negedge Rst_n) begin
    if (!Rst_n) begin
      sh_mode   <= MODE_SOLID;
      sh_fill   <= '0;
      x0        <= '0;
      frame_cnt <= '0;
      RGB24     <= '0;
    end else begin
      RGB24 <= pix_c;
      if (origin_c) begin
        sh_mode   <= mode_eff_c;
        sh_fill   <= fill_eff_c;
        x0        <= x0_nxt_c;
        frame_cnt <= frame_cnt_nxt_c;
      end
    end
  end

endmodule
